// File: rtl/cla_add_sequencer_pkg.sv
// Shared constants and FSM state type for the multi-precision add/subtract sequencer.
package cla_add_sequencer_pkg;

  localparam int unsigned BeatW  = 16;
  localparam int unsigned NumReq = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/cla_add_sequencer_if.sv
// Request/response bundle between the two issue clients, the consumer and the sequencer.
interface cla_add_sequencer_if #(
  parameter int unsigned WORDS = 4
);
  import cla_add_sequencer_pkg::*;

  localparam int unsigned W = BeatW * WORDS;

  logic [NumReq-1:0] req_valid;
  logic [NumReq-1:0] req_ready;
  logic [W-1:0]      req_a0;
  logic [W-1:0]      req_b0;
  logic              req_sub0;
  logic [W-1:0]      req_a1;
  logic [W-1:0]      req_b1;
  logic              req_sub1;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              rsp_ovf;

  modport master (
    output req_valid, req_a0, req_b0, req_sub0, req_a1, req_b1, req_sub1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_sub0, req_a1, req_b1, req_sub1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

endinterface

// File: rtl/carry_lookahead_adder_16bit.sv
// 16-bit adder: four 4-bit groups with group generate/propagate and lookahead group carries.
module carry_lookahead_adder_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_cg;
  logic        w_c;

  always_comb begin
    w_g = i_a & i_b;
    w_p = i_a ^ i_b;
    for (int j = 0; j < 4; j++) begin
      w_gg[j] = w_g[4*j+3]
              | (w_p[4*j+3] & w_g[4*j+2])
              | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
              | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
      w_gp[j] = &w_p[4*j +: 4];
    end

    w_cg[0] = i_cin;
    w_cg[1] = w_gg[0] | (w_gp[0] & i_cin);
    w_cg[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
    w_cg[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    w_cg[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

    // Bit carries inside each group start from that group's lookahead carry.
    o_sum = '0;
    w_c   = 1'b0;
    for (int j = 0; j < 4; j++) begin
      w_c = w_cg[j];
      for (int i = 0; i < 4; i++) begin
        o_sum[4*j+i] = w_p[4*j+i] ^ w_c;
        w_c          = w_g[4*j+i] | (w_p[4*j+i] & w_c);
      end
    end
    o_cout = w_cg[4];
  end

endmodule

// File: rtl/cla_add_sequencer.sv
// Round-robin shares one 16-bit CLA between two requesters, running each W-bit add/sub
// least-significant beat first with the carry chained through a register.
module cla_add_sequencer
  import cla_add_sequencer_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  cla_add_sequencer_if.slave bus
);

  localparam int unsigned W        = BeatW * WORDS;
  localparam int unsigned BeatCntW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(WORDS - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic                r_last_grant;
  logic                r_id;
  logic                r_sub;
  logic                r_carry;
  logic [BeatCntW-1:0] r_beat;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [W-1:0]        r_sum;

  logic [NumReq-1:0]   w_grant;
  logic                w_accept;
  logic                w_done;
  logic                w_last_beat;
  logic                w_sel_sub;
  logic [W-1:0]        w_sel_a;
  logic [W-1:0]        w_sel_b;
  logic [W-1:0]        w_sum_next;
  logic [BeatW-1:0]    w_add_a;
  logic [BeatW-1:0]    w_add_b;
  logic [BeatW-1:0]    w_add_sum;
  logic                w_add_cin;
  logic                w_add_cout;

  // Contention goes to whichever requester was not granted last.
  always_comb begin
    w_grant = '0;
    if (&bus.req_valid) begin
      w_grant = r_last_grant ? 2'b01 : 2'b10;
    end else begin
      w_grant = bus.req_valid;
    end
  end

  assign bus.req_ready = (r_state == StIdle) ? w_grant : '0;
  assign w_accept      = |bus.req_ready;
  assign w_sel_a       = w_grant[1] ? bus.req_a1   : bus.req_a0;
  assign w_sel_b       = w_grant[1] ? bus.req_b1   : bus.req_b0;
  assign w_sel_sub     = w_grant[1] ? bus.req_sub1 : bus.req_sub0;
  assign w_last_beat   = (r_beat == LastBeat);
  assign w_done        = (r_state == StDone);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StRun;
      StRun:   if (w_last_beat) w_state_next = StDone;
      StDone:  if (bus.rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_add_a    = '0;
    w_add_b    = '0;
    w_sum_next = r_sum;
    for (int k = 0; k < int'(WORDS); k++) begin
      if (r_beat == k[BeatCntW-1:0]) begin
        w_add_a = r_a[k*BeatW +: BeatW];
        w_add_b = r_b[k*BeatW +: BeatW];
        w_sum_next[k*BeatW +: BeatW] = w_add_sum;
      end
    end
  end

  // The +1 of a subtract enters as the carry-in of beat 0.
  assign w_add_cin = (r_beat == '0) ? r_sub : r_carry;

  carry_lookahead_adder_16bit u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_sub        <= 1'b0;
      r_carry      <= 1'b0;
      r_beat       <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant[1];
        r_id         <= w_grant[1];
        r_sub        <= w_sel_sub;
        r_a          <= w_sel_a;
        r_b          <= w_sel_sub ? ~w_sel_b : w_sel_b;
        r_beat       <= '0;
      end
      if (r_state == StRun) begin
        r_sum   <= w_sum_next;
        r_carry <= w_add_cout;
        r_beat  <= r_beat + 1'b1;
      end
    end
  end

  assign bus.rsp_valid = w_done;
  assign bus.rsp_id    = w_done & r_id;
  assign bus.rsp_sum   = w_done ? r_sum : '0;
  assign bus.rsp_cout  = w_done & r_carry;
  assign bus.rsp_ovf   = w_done & (r_a[W-1] == r_b[W-1]) & (r_sum[W-1] != r_a[W-1]);

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Directed bench for cla_add_sequencer: arithmetic corners, latency, fairness, stall, reset.
module tb_cla_add_sequencer;

  localparam int unsigned WORDS = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cla_add_sequencer_if #(.WORDS(WORDS)) bus ();

  cla_add_sequencer #(.WORDS(WORDS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid = 2'b00;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_sub0 = 1'b0;
    bus.req_a1 = '0; bus.req_b1 = '0; bus.req_sub1 = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"},   64'(bus.req_ready), 64'd0);
    chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_id"},    64'(bus.rsp_id),    64'd0);
    chk({tag, "_sum"},   bus.rsp_sum,        64'd0);
    chk({tag, "_cout"},  64'(bus.rsp_cout),  64'd0);
    chk({tag, "_ovf"},   64'(bus.rsp_ovf),   64'd0);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp);
    int n = 0;
    while (bus.req_ready == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(bus.req_ready), 64'(exp));
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // One isolated operation from requester id, with latency and full response checks.
  task automatic do_op(input string tag, input int id, input logic [63:0] a,
                       input logic [63:0] b, input logic sub, input logic [63:0] exp_sum,
                       input logic exp_cout, input logic exp_ovf);
    int lat;
    if (id == 0) begin
      bus.req_a0 = a; bus.req_b0 = b; bus.req_sub0 = sub; bus.req_valid = 2'b01;
    end else begin
      bus.req_a1 = a; bus.req_b1 = b; bus.req_sub1 = sub; bus.req_valid = 2'b10;
    end
    #1;
    wait_grant({tag, "_grant"}, (id == 0) ? 2'b01 : 2'b10);
    tick();
    bus.req_valid = 2'b00;
    bus.req_a0 = ~a; bus.req_b0 = ~b; bus.req_sub0 = ~sub;
    bus.req_a1 = ~a; bus.req_b1 = ~b; bus.req_sub1 = ~sub;
    wait_rsp(lat);
    chk({tag, "_lat"},   64'(lat + 1),       64'd5);
    chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, "_sum"},   bus.rsp_sum,        exp_sum);
    chk({tag, "_cout"},  64'(bus.rsp_cout),  64'(exp_cout));
    chk({tag, "_ovf"},   64'(bus.rsp_ovf),   64'(exp_ovf));
    chk({tag, "_id"},    64'(bus.rsp_id),    64'(id));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    clear_reqs();
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;

    do_op("t1_carry", 0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
          64'h0000_0000_0001_0000, 1'b0, 1'b0);
    do_op("t2_ripple", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
    do_op("t3_sub", 1, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    do_op("t3_ovf", 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_op("t3_subovf", 1, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Round-robin under continuous contention, starting from reset.
    rst = 1'b1;
    tick();
    bus.req_a0 = 64'h1111_1111_1111_1111; bus.req_b0 = 64'h2222_2222_2222_2222;
    bus.req_sub0 = 1'b0;
    bus.req_a1 = 64'h10; bus.req_b1 = 64'h3; bus.req_sub1 = 1'b1;
    bus.req_valid = 2'b11;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      wait_grant("t4_grant", (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      wait_rsp(lat);
      chk("t4_id", 64'(bus.rsp_id), 64'(i % 2));
      chk("t4_sum", bus.rsp_sum, (i % 2 == 0) ? 64'h3333_3333_3333_3333 : 64'hD);
      tick();
    end
    clear_reqs();

    // Backpressure: hold DONE for 10 cycles with both requesters waiting.
    bus.rsp_ready = 1'b0;
    bus.req_a0 = 64'd3; bus.req_b0 = 64'd4; bus.req_valid = 2'b01;
    #1;
    wait_grant("t5_grant", 2'b01);
    tick();
    bus.req_a1 = 64'h100; bus.req_b1 = 64'h20; bus.req_sub1 = 1'b0;
    bus.req_a0 = 64'hDEAD; bus.req_valid = 2'b11;
    wait_rsp(lat);
    for (int i = 0; i < 10; i++) begin
      chk("t5_stall_rdy",   64'(bus.req_ready), 64'd0);
      chk("t5_stall_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t5_stall_sum",   bus.rsp_sum,        64'd7);
      chk("t5_stall_id",    64'(bus.rsp_id),    64'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t5_rise_rdy", 64'(bus.req_ready), 64'd0);
    tick();
    chk("t5_accept", 64'(bus.req_ready), 64'b10);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(lat);
    chk("t5_next_id",  64'(bus.rsp_id), 64'd1);
    chk("t5_next_sum", bus.rsp_sum,     64'h120);
    tick();
    clear_reqs();

    // Reset at beat 2 discards the operation and restores last_grant.
    bus.req_a0 = 64'd1; bus.req_b0 = 64'd1; bus.req_valid = 2'b01;
    #1;
    wait_grant("t6_grant", 2'b01);
    tick();
    bus.req_valid = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("t6_reset");
    for (int i = 0; i < 8; i++) begin
      chk("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
      tick();
    end
    bus.req_a1 = 64'd9; bus.req_b1 = 64'd9; bus.req_valid = 2'b11;
    #1;
    chk("t6_contend", 64'(bus.req_ready), 64'b01);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(lat);
    chk("t6_after_id",  64'(bus.rsp_id), 64'd0);
    chk("t6_after_sum", bus.rsp_sum,     64'd2);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
